cam_search_ctrl: RTL and testbench

//  Requester/reader side of a CAM_RAM lookup port: accepts search requests (tag + age head pointer),

---
 rtl/cam_search_ctrl_pkg.sv | 15 +
 rtl/circ_prio_enc.sv | 34 +++
 rtl/cam_search_ctrl.sv | 134 +++++++++++++
 tb/tb_cam_search_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_search_ctrl_pkg.sv
// Shared types and default geometry for the CAM search requester.
// Optional feature macro used by the top: CAM_SEARCH_MULTIHIT_EN.
package cam_search_ctrl_pkg;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_LOOKUP,
    CS_RESP
  } camSearchState_t;

  localparam int unsigned CS_DEPTH = 32;
  localparam int unsigned CS_INDEX = 5;
  localparam int unsigned CS_WIDTH = 7;

endpackage

// File: rtl/circ_prio_enc.sv
// Circular priority encoder: first set bit of vect_i at or after head_i, wrapping modulo DEPTH.
// DEPTH must equal 2**INDEX so the index sum wraps naturally.
module circ_prio_enc
  import cam_search_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = CS_DEPTH,
  parameter int unsigned INDEX = CS_INDEX
) (
  input  logic [DEPTH-1:0] vect_i,
  input  logic [INDEX-1:0] head_i,
  output logic             hit_o,
  output logic [INDEX-1:0] index_o
);

  logic [2*DEPTH-1:0] dbl;
  logic [DEPTH-1:0]   rot;
  logic [INDEX-1:0]   pos;

  always_comb begin
    // Rotating right by head puts entry head at bit 0, so the lowest set bit is the oldest match.
    dbl   = {vect_i, vect_i} >> head_i;
    rot   = dbl[DEPTH-1:0];
    pos   = '0;
    hit_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos   = i[INDEX-1:0];
        hit_o = 1'b1;
      end
    end
    index_o = hit_o ? (head_i + pos) : '0;
  end

endmodule

// File: rtl/cam_search_ctrl.sv
// Requester side of a CAM lookup port: accept tag+head, run one CAM read cycle, return the oldest match.
// Defining CAM_SEARCH_MULTIHIT_EN adds rspMulti_o (more than one entry matched).
module cam_search_ctrl
  import cam_search_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = CS_DEPTH,
  parameter int unsigned INDEX = CS_INDEX,
  parameter int unsigned WIDTH = CS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             camReady_i,
  input  logic             reqValid_i,
  output logic             reqReady_o,
  input  logic [WIDTH-1:0] reqTag_i,
  input  logic [INDEX-1:0] reqHead_i,
  output logic [WIDTH-1:0] camTag_o,
  output logic             camGated_o,
  input  logic [DEPTH-1:0] camVect_i,
  output logic             rspValid_o,
  input  logic             rspReady_i,
  output logic             rspHit_o,
  output logic [INDEX-1:0] rspIndex_o
`ifdef CAM_SEARCH_MULTIHIT_EN
  ,
  output logic             rspMulti_o
`endif
);

  // Both handshakes are valid/ready: a transfer happens on a cycle where valid and ready are both high;
  // rspValid_o and the response fields hold steady until that transfer.

  camSearchState_t  state_q, state_d;
  logic [WIDTH-1:0] tag_q, tag_d;
  logic [INDEX-1:0] head_q, head_d;
  logic             hit_q, hit_d;
  logic [INDEX-1:0] index_q, index_d;
  logic             enc_hit;
  logic [INDEX-1:0] enc_index;
  logic             accept;
`ifdef CAM_SEARCH_MULTIHIT_EN
  localparam logic [DEPTH-1:0] VectOne = 1;
  logic             multi_q, multi_d;
`endif

  circ_prio_enc #(
    .DEPTH (DEPTH),
    .INDEX (INDEX)
  ) u_enc (
    .vect_i  (camVect_i),
    .head_i  (head_q),
    .hit_o   (enc_hit),
    .index_o (enc_index)
  );

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    head_d     = head_q;
    hit_d      = hit_q;
    index_d    = index_q;
`ifdef CAM_SEARCH_MULTIHIT_EN
    multi_d    = multi_q;
`endif
    reqReady_o = 1'b0;
    camGated_o = 1'b1;
    camTag_o   = '0;
    rspValid_o = 1'b0;

    case (state_q)
      CS_IDLE: begin
        reqReady_o = camReady_i & ~flush_i;
      end
      CS_LOOKUP: begin
        camGated_o = 1'b0;
        camTag_o   = tag_q;
        hit_d      = enc_hit;
        index_d    = enc_index;
`ifdef CAM_SEARCH_MULTIHIT_EN
        multi_d    = |(camVect_i & (camVect_i - VectOne));
`endif
        state_d    = CS_RESP;
      end
      CS_RESP: begin
        rspValid_o = 1'b1;
        reqReady_o = rspReady_i & camReady_i & ~flush_i;
        if (rspReady_i) state_d = CS_IDLE;
      end
      default: state_d = CS_IDLE;
    endcase

    if (reset) reqReady_o = 1'b0;

    // A new accept in RESP implies the response handshake too, so it simply overrides the IDLE return.
    accept = reqValid_i & reqReady_o;
    if (accept) begin
      tag_d   = reqTag_i;
      head_d  = reqHead_i;
      state_d = CS_LOOKUP;
    end

    if (flush_i) state_d = CS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CS_IDLE;
      tag_q   <= '0;
      head_q  <= '0;
      hit_q   <= 1'b0;
      index_q <= '0;
`ifdef CAM_SEARCH_MULTIHIT_EN
      multi_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      head_q  <= head_d;
      hit_q   <= hit_d;
      index_q <= index_d;
`ifdef CAM_SEARCH_MULTIHIT_EN
      multi_q <= multi_d;
`endif
    end
  end

  assign rspHit_o   = hit_q;
  assign rspIndex_o = index_q;
`ifdef CAM_SEARCH_MULTIHIT_EN
  assign rspMulti_o = multi_q;
`endif

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Directed bench for cam_search_ctrl with a behavioural CAM lane (tag -> match vector table).
// Build with CAM_SEARCH_MULTIHIT_EN defined to also check rspMulti_o.
module tb_cam_search_ctrl;

  localparam int DEPTH = 32;
  localparam int INDEX = 5;
  localparam int WIDTH = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_i;
  logic             camReady_i;
  logic             reqValid_i;
  logic             reqReady_o;
  logic [WIDTH-1:0] reqTag_i;
  logic [INDEX-1:0] reqHead_i;
  logic [WIDTH-1:0] camTag_o;
  logic             camGated_o;
  logic [DEPTH-1:0] camVect_i;
  logic             rspValid_o;
  logic             rspReady_i;
  logic             rspHit_o;
  logic [INDEX-1:0] rspIndex_o;
`ifdef CAM_SEARCH_MULTIHIT_EN
  logic             rspMulti_o;
`endif

  logic [DEPTH-1:0] cam_tbl [0:(1<<WIDTH)-1];
  logic             multi_sink;
  int               n_checks = 0;
  int               n_fail   = 0;

  cam_search_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .camReady_i (camReady_i),
    .reqValid_i (reqValid_i),
    .reqReady_o (reqReady_o),
    .reqTag_i   (reqTag_i),
    .reqHead_i  (reqHead_i),
    .camTag_o   (camTag_o),
    .camGated_o (camGated_o),
    .camVect_i  (camVect_i),
    .rspValid_o (rspValid_o),
    .rspReady_i (rspReady_i),
    .rspHit_o   (rspHit_o),
    .rspIndex_o (rspIndex_o)
`ifdef CAM_SEARCH_MULTIHIT_EN
    ,
    .rspMulti_o (rspMulti_o)
`endif
  );

  // Clock / CAM model
  always #5 clk = ~clk;
  assign camVect_i = camGated_o ? '0 : cam_tbl[camTag_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one cycle after the accepting edge (DUT in LOOKUP).
  task automatic send(input logic [WIDTH-1:0] tag, input logic [INDEX-1:0] head);
    reqValid_i = 1'b1;
    reqTag_i   = tag;
    reqHead_i  = head;
    #1;
    for (int i = 0; i < 10 && !reqReady_o; i++) tick();
    check("accept_ready", reqReady_o, 1);
    tick();
    reqValid_i = 1'b0;
  endtask

  task automatic check_rsp(input string name, input logic hit, input logic [INDEX-1:0] idx,
                           input logic multi);
    check({name, "_valid"}, rspValid_o, 1);
    check({name, "_hit"}, rspHit_o, hit);
    check({name, "_idx"}, rspIndex_o, idx);
`ifdef CAM_SEARCH_MULTIHIT_EN
    check({name, "_multi"}, rspMulti_o, multi);
`else
    multi_sink = multi;
`endif
  endtask

  task automatic search(input string name, input logic [WIDTH-1:0] tag, input logic [INDEX-1:0] head,
                        input logic [DEPTH-1:0] vect, input logic hit, input logic [INDEX-1:0] idx,
                        input logic multi);
    cam_tbl[tag] = vect;
    rspReady_i   = 1'b0;
    send(tag, head);
    check({name, "_lk_gated"}, camGated_o, 0);
    check({name, "_lk_tag"}, camTag_o, tag);
    check({name, "_lk_valid"}, rspValid_o, 0);
    tick();
    check({name, "_rs_gated"}, camGated_o, 1);
    check({name, "_rs_tag"}, camTag_o, 0);
    check_rsp(name, hit, idx, multi);
    rspReady_i = 1'b1;
    tick();
    rspReady_i = 1'b0;
    check({name, "_done"}, rspValid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    flush_i    = 1'b0;
    camReady_i = 1'b1;
    reqValid_i = 1'b0;
    rspReady_i = 1'b0;
    reqTag_i   = '0;
    reqHead_i  = '0;
    multi_sink = 1'b0;
    for (int i = 0; i < (1 << WIDTH); i++) cam_tbl[i] = '0;

    // Reset held three cycles
    repeat (3) tick();
    check("rst_valid", rspValid_o, 0);
    check("rst_gated", camGated_o, 1);
    check("rst_ready", reqReady_o, 0);
    check("rst_tag", camTag_o, 0);
    check("rst_hit", rspHit_o, 0);
    check("rst_idx", rspIndex_o, 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", reqReady_o, 1);

    // Resolution patterns
    search("basic",   7'h05, 5'd0,  32'h0000_0110, 1'b1, 5'd4,  1'b1);
    search("wrap_hi", 7'h06, 5'd30, 32'h4000_0003, 1'b1, 5'd30, 1'b1);
    search("wrap_lo", 7'h07, 5'd30, 32'h0000_0003, 1'b1, 5'd0,  1'b1);
    search("lowprio", 7'h08, 5'd5,  32'h0000_0010, 1'b1, 5'd4,  1'b0);

    // Miss under backpressure
    cam_tbl[9] = '0;
    rspReady_i = 1'b0;
    send(7'h09, 5'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_rsp("miss_hold", 1'b0, 5'd0, 1'b0);
      tick();
    end
    check_rsp("miss_last", 1'b0, 5'd0, 1'b0);
    rspReady_i = 1'b1;
    tick();
    rspReady_i = 1'b0;
    check("miss_done", rspValid_o, 0);

    // Back-to-back requests
    cam_tbl[10] = 32'h0000_0008;
    cam_tbl[11] = 32'h8000_0000;
    rspReady_i  = 1'b1;
    send(7'h0A, 5'd0);
    reqValid_i = 1'b1;
    reqTag_i   = 7'h0B;
    reqHead_i  = 5'd4;
    #1;
    check("b2b_lk_ready", reqReady_o, 0);
    tick();
    check_rsp("b2b_a", 1'b1, 5'd3, 1'b0);
    check("b2b_a_ready", reqReady_o, 1);
    tick();
    reqValid_i = 1'b0;
    check("b2b_gap_valid", rspValid_o, 0);
    check("b2b_gap_tag", camTag_o, 7'h0B);
    tick();
    check_rsp("b2b_b", 1'b1, 5'd31, 1'b0);
    tick();
    rspReady_i = 1'b0;
    check("b2b_done", rspValid_o, 0);

    // camReady low blocks accepts but not an in-flight search
    cam_tbl[12] = 32'h0000_0001;
    camReady_i  = 1'b0;
    reqValid_i  = 1'b1;
    reqTag_i    = 7'h0C;
    #1;
    check("crdy_blocked", reqReady_o, 0);
    tick();
    check("crdy_no_lookup", camGated_o, 1);
    camReady_i = 1'b1;
    send(7'h0C, 5'd0);
    camReady_i = 1'b0;
    tick();
    check_rsp("crdy_low", 1'b1, 5'd0, 1'b0);
    camReady_i = 1'b1;
    rspReady_i = 1'b1;
    tick();
    rspReady_i = 1'b0;

    // Flush during LOOKUP
    cam_tbl[13] = 32'h0000_0002;
    send(7'h0D, 5'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_lk_valid", rspValid_o, 0);
    check("fl_lk_gated", camGated_o, 1);
    #1;
    check("fl_lk_idle_ready", reqReady_o, 1);
    tick();
    check("fl_lk_no_rsp", rspValid_o, 0);

    // Flush during RESP, with a competing request
    send(7'h0D, 5'd0);
    tick();
    check("fl_rs_pre_valid", rspValid_o, 1);
    rspReady_i = 1'b1;
    flush_i    = 1'b1;
    reqValid_i = 1'b1;
    reqTag_i   = 7'h0D;
    #1;
    check("fl_rs_ready", reqReady_o, 0);
    tick();
    flush_i    = 1'b0;
    reqValid_i = 1'b0;
    rspReady_i = 1'b0;
    check("fl_rs_valid", rspValid_o, 0);
    check("fl_rs_gated", camGated_o, 1);
    tick();
    check("fl_rs_still_idle", rspValid_o, 0);

    // Reset mid-search
    send(7'h0D, 5'd0);
    reset = 1'b1;
    tick();
    check("rst_mid_valid", rspValid_o, 0);
    check("rst_mid_ready", reqReady_o, 0);
    reset = 1'b0;
    tick();
    check("rst_mid_no_rsp", rspValid_o, 0);
    check("rst_mid_ready_after", reqReady_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
